// File: rtl/synth_input_pkg.sv
// Shared types and defaults for the octave push-button front end.
package synth_input_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    PRESSED  = 2'd2,
    REL_DB   = 2'd3
  } key_db_state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 10000;
  localparam int REPEAT_CYCLES_DEF   = 0;

  // Counter width large enough to hold the larger of the two terminal counts.
  function automatic int cnt_width(input int db, input int rpt);
    return $clog2(((db > rpt) ? db : rpt) + 1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button channel: 2-FF synchroniser, debounce FSM, optional
// hold-to-repeat, and a registered single-cycle pulse.
module key_debounce
  import synth_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF,
  parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES, REPEAT_CYCLES)
) (
  input  logic clk,
  input  logic n_rst,
  input  logic key_raw,
  output logic pulse
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  key_db_state_t    state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] rcnt;

  // Stage p0/p1: metastability guard for the asynchronous button input
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= key_raw;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce / repeat FSM on the synchronised level
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      cnt   <= '0;
      rcnt  <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (sync_p1) begin
            state <= PRESS_DB;
            cnt   <= '0;
          end
        end
        PRESS_DB: begin
          if (!sync_p1) begin
            state <= IDLE;
          end else if (cnt == DB_LAST) begin
            state <= PRESSED;
            pulse <= 1'b1;
            rcnt  <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!sync_p1) begin
            state <= REL_DB;
            cnt   <= '0;
          end else if ((REPEAT_CYCLES != 0) && (rcnt == RPT_LAST)) begin
            pulse <= 1'b1;
            rcnt  <= '0;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        REL_DB: begin
          // A bounce back high during release resumes the held press silently
          if (sync_p1) begin
            state <= PRESSED;
            rcnt  <= '0;
          end else if (cnt == DB_LAST) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/octave_key_conditioner.sv
// Two debounced octave keys with same-cycle collision suppression; outputs
// come only from registered channel pulses.
module octave_key_conditioner
  import synth_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF,
  parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES, REPEAT_CYCLES)
) (
  input  logic clk,
  input  logic n_rst,
  input  logic key_up_raw,
  input  logic key_down_raw,
  output logic octave_key_up,
  output logic octave_key_down
);

  logic up_p;
  logic dn_p;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_up (
    .clk    (clk),
    .n_rst  (n_rst),
    .key_raw(key_up_raw),
    .pulse  (up_p)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_dn (
    .clk    (clk),
    .n_rst  (n_rst),
    .key_raw(key_down_raw),
    .pulse  (dn_p)
  );

  // Simultaneous pulses are ambiguous, so both are discarded
  assign octave_key_up   = up_p & ~dn_p;
  assign octave_key_down = dn_p & ~up_p;

endmodule

// File: tb/tb_octave_key_conditioner.sv
// Bench for octave_key_conditioner: one instance without repeat, one with
// an 8-cycle repeat, both with a 4-cycle debounce.
module tb_octave_key_conditioner;

  logic clk = 1'b0;
  logic n_rst;
  logic up0, dn0, up1, dn1;
  logic o_up0, o_dn0, o_up1, o_dn1;

  always #5 clk = ~clk;

  octave_key_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(0)) dut (
    .clk(clk), .n_rst(n_rst), .key_up_raw(up0), .key_down_raw(dn0),
    .octave_key_up(o_up0), .octave_key_down(o_dn0)
  );

  octave_key_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(8)) dut_rpt (
    .clk(clk), .n_rst(n_rst), .key_up_raw(up1), .key_down_raw(dn1),
    .octave_key_up(o_up1), .octave_key_down(o_dn1)
  );

  typedef struct {
    int edge_n;
    int inst;
    bit up;
    bit dn;
  } exp_t;

  typedef struct {
    string name;
    int    up_on;
    int    up_len;
    int    dn_on;
    int    dn_len;
    int    exp_up;
    int    exp_dn;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[7];
  int   ecnt = -1;
  int   n_cmp = 0;
  int   n_bad = 0;
  string tag = "reset";

  task automatic push(input int e, input int inst, input bit up, input bit dn);
    exp_t x;
    x.edge_n = e; x.inst = inst; x.up = up; x.dn = dn;
    sb.push_back(x);
  endtask

  task automatic cmp(input string nm, input logic act, input bit exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s/%s edge %0d: got %b want %b", tag, nm, ecnt, act, exp);
    end
  endtask

  // Advance one edge, then check all four outputs against the scoreboard
  task automatic tick();
    bit eu0, ed0, eu1, ed1;
    @(posedge clk);
    ecnt++;
    #1;
    eu0 = 0; ed0 = 0; eu1 = 0; ed1 = 0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].edge_n == ecnt) begin
        if (sb[i].inst == 0) begin
          eu0 |= sb[i].up; ed0 |= sb[i].dn;
        end else begin
          eu1 |= sb[i].up; ed1 |= sb[i].dn;
        end
        sb.delete(i);
      end
    end
    cmp("up", o_up0, eu0);
    cmp("dn", o_dn0, ed0);
    cmp("rpt_up", o_up1, eu1);
    cmp("rpt_dn", o_dn1, ed1);
  endtask

  task automatic idle(input int n);
    up0 = 0; dn0 = 0; up1 = 0; dn1 = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int base;
    bit pat[8];

    vecs[0] = '{"clean_up",     0, 20, 0, 0,  6, -1};
    vecs[1] = '{"clean_dn",     0, 0,  0, 20, -1, 6};
    vecs[2] = '{"collide",      0, 20, 0, 20, -1, -1};
    vecs[3] = '{"offset",       0, 20, 1, 20, 6,  7};
    vecs[4] = '{"short3",       0, 3,  0, 0,  -1, -1};
    vecs[5] = '{"edge_len5",    0, 5,  0, 0,  6,  -1};
    vecs[6] = '{"edge_len4",    0, 4,  0, 0,  -1, -1};

    n_rst = 1'b0;
    up0 = 0; dn0 = 0; up1 = 0; dn1 = 0;
    tick();
    tick();
    n_rst = 1'b1;
    tag = "post_reset";
    idle(3);

    for (int v = 0; v < 7; v++) begin
      tag = vecs[v].name;
      base = ecnt + 1;
      if (vecs[v].exp_up >= 0) push(base + vecs[v].exp_up, 0, 1'b1, 1'b0);
      if (vecs[v].exp_dn >= 0) push(base + vecs[v].exp_dn, 0, 1'b0, 1'b1);
      for (int k = 0; k < 40; k++) begin
        up0 = (k >= vecs[v].up_on) && (k < vecs[v].up_on + vecs[v].up_len);
        dn0 = (k >= vecs[v].dn_on) && (k < vecs[v].dn_on + vecs[v].dn_len);
        tick();
      end
      idle(4);
    end

    // Bounce: low sample at edge 2 restarts the debounce from edge 3
    tag = "bounce";
    pat = '{1, 1, 0, 1, 1, 1, 1, 1};
    base = ecnt + 1;
    push(base + 9, 0, 1'b1, 1'b0);
    for (int k = 0; k < 40; k++) begin
      up0 = (k < 8) ? pat[k] : (k < 20);
      tick();
    end
    idle(4);

    // Short release glitch, then a real release and re-press
    tag = "rel_glitch";
    base = ecnt + 1;
    push(base + 6, 0, 1'b1, 1'b0);
    push(base + 45 + 6, 0, 1'b1, 1'b0);
    for (int k = 0; k < 75; k++) begin
      up0 = (k < 20) || (k >= 22 && k < 40) || (k >= 45 && k < 60);
      tick();
    end
    idle(4);

    tag = "repeat";
    base = ecnt + 1;
    for (int p = 0; p < 5; p++) push(base + 6 + 8 * p, 1, 1'b1, 1'b0);
    for (int k = 0; k < 60; k++) begin
      up1 = (k < 40);
      tick();
    end
    idle(4);

    // Reset mid-press: first press lost, new press counted from release
    tag = "mid_reset";
    base = ecnt + 1;
    push(base + 15, 0, 1'b1, 1'b0);
    for (int k = 0; k < 40; k++) begin
      up0 = (k < 26);
      tick();
      if (ecnt == base + 4) n_rst = 1'b0;
      if (ecnt == base + 8) n_rst = 1'b1;
    end
    idle(4);

    tag = "drain";
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL %s: got %0d pending pulses want 0", tag, sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
